// File: rtl/layer_result_writer.sv
// Layer result writer: buffers per-cycle layer results in a FIFO and drains
// them to DDR3 as single-word writes at consecutive addresses from a per-layer
// base, with almost-full backpressure and a flush/done handshake.
module layer_result_writer #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter int ALMOST_FULL_MARGIN = 4,
  parameter int ADDR_STRIDE        = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  Layer_Start,
  input  logic [ADDR_WIDTH-1:0] Base_Addr,
  input  logic                  Layer_End,
  input  logic [DATA_WIDTH-1:0] Result_Data,
  input  logic                  Result_Valid,
  input  logic                  DDR3_Write_Ack,
  output logic [ADDR_WIDTH-1:0] DDR3_Address,
  output logic [DATA_WIDTH-1:0] DDR3_Write_Data,
  output logic                  DDR3_WE,
  output logic                  Almost_Full,
  output logic                  Flush_Done,
  output logic [31:0]           Words_Written,
  output logic                  Drop_Err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]            state_q,    state_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]      count_q,    count_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
  logic [31:0]           words_q,    words_d;
  logic                  drop_err_q, drop_err_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic we, pop, push, full;

  // Write request, push/pop qualification and next-state computation
  always_comb begin
    we   = (state_q != ST_IDLE) && (count_q != '0);
    pop  = we && DDR3_Write_Ack;
    full = (count_q == CNT_W'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push = Result_Valid && (state_q == ST_RUN) && (!full || pop);

    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    wr_addr_d  = wr_addr_q;
    words_d    = words_q;
    drop_err_d = drop_err_q;

    if (Result_Valid && !push) drop_err_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      wr_addr_d = wr_addr_q + ADDR_WIDTH'(ADDR_STRIDE);
      if (words_q != '1) words_d = words_q + 32'd1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (Layer_Start) begin
          state_d   = ST_RUN;
          wr_addr_d = Base_Addr;
          words_d   = '0;
        end
      end
      ST_RUN: begin
        if (Layer_End) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (count_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wr_addr_q  <= '0;
      words_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wr_addr_q  <= wr_addr_d;
      words_q    <= words_d;
      drop_err_q <= drop_err_d;
    end
  end

  // FIFO storage; contents are invalidated by the pointer reset alone
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= Result_Data;
  end

  // Output drive: DDR3 fields are zero whenever no request is presented
  always_comb begin
    DDR3_WE         = we;
    DDR3_Address    = we ? wr_addr_q : '0;
    DDR3_Write_Data = we ? mem_q[rd_ptr_q] : '0;
    Almost_Full     = (count_q >= CNT_W'(FIFO_DEPTH - ALMOST_FULL_MARGIN));
    Flush_Done      = (state_q == ST_FLUSH) && (count_q == '0);
    Words_Written   = words_q;
    Drop_Err        = drop_err_q;
  end

endmodule

// File: tb/tb_layer_result_writer.sv
// Scoreboard bench for layer_result_writer: a behavioural model predicts
// accepted words and their addresses; a negedge monitor checks every write.
module tb_layer_result_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Layer_Start = 1'b0;
  logic [31:0] Base_Addr = '0;
  logic        Layer_End = 1'b0;
  logic [31:0] Result_Data = '0;
  logic        Result_Valid = 1'b0;
  logic        DDR3_Write_Ack = 1'b0;
  logic [31:0] DDR3_Address;
  logic [31:0] DDR3_Write_Data;
  logic        DDR3_WE;
  logic        Almost_Full;
  logic        Flush_Done;
  logic [31:0] Words_Written;
  logic        Drop_Err;

  layer_result_writer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(16),
    .ALMOST_FULL_MARGIN(4), .ADDR_STRIDE(4)
  ) dut (
    .clock(clock), .reset(reset), .Layer_Start(Layer_Start), .Base_Addr(Base_Addr),
    .Layer_End(Layer_End), .Result_Data(Result_Data), .Result_Valid(Result_Valid),
    .DDR3_Write_Ack(DDR3_Write_Ack), .DDR3_Address(DDR3_Address),
    .DDR3_Write_Data(DDR3_Write_Data), .DDR3_WE(DDR3_WE), .Almost_Full(Almost_Full),
    .Flush_Done(Flush_Done), .Words_Written(Words_Written), .Drop_Err(Drop_Err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: layer phase, occupancy, and expected write stream
  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2;
  int          mstate = M_IDLE;
  int          occ    = 0;
  logic [31:0] mwords = '0;
  logic        mdrop  = 1'b0;
  logic [31:0] mbase  = '0;
  logic [31:0] macc   = '0;
  logic [63:0] sb[$];
  int          flush_cnt = 0;

  always @(posedge clock or posedge reset) begin
    bit pop_m, push_m;
    int occ_pre;
    if (reset) begin
      mstate = M_IDLE; occ = 0; mwords = '0; mdrop = 1'b0; sb.delete();
    end else begin
      occ_pre = occ;
      pop_m  = (mstate != M_IDLE) && (occ > 0) && DDR3_Write_Ack;
      push_m = Result_Valid && (mstate == M_RUN) && ((occ < 16) || pop_m);
      if (Result_Valid && !push_m) mdrop = 1'b1;
      if (push_m) begin
        sb.push_back({mbase + macc * 32'd4, Result_Data});
        macc = macc + 32'd1;
      end
      if (pop_m && mwords != 32'hFFFF_FFFF) mwords = mwords + 32'd1;
      occ = occ + int'(push_m) - int'(pop_m);
      case (mstate)
        M_IDLE:  if (Layer_Start) begin
                   mstate = M_RUN; mbase = Base_Addr; macc = '0; mwords = '0;
                 end
        M_RUN:   if (Layer_End) mstate = M_FLUSH;
        default: if (occ_pre == 0) mstate = M_IDLE;
      endcase
    end
  end

  // Monitor: per-cycle flag checks, and a scoreboard pop on every acked write
  always @(negedge clock) begin
    logic [63:0] e;
    chk("we", DDR3_WE, (mstate != M_IDLE) && (occ > 0));
    chk("almost_full", Almost_Full, occ >= 12);
    chk("flush_done", Flush_Done, (mstate == M_FLUSH) && (occ == 0));
    chk("words_written", Words_Written, mwords);
    chk("drop_err", Drop_Err, mdrop);
    if (!DDR3_WE) chk("idle_bus", {DDR3_Address, DDR3_Write_Data}, 64'd0);
    if (Flush_Done) flush_cnt++;
    if (DDR3_WE && DDR3_Write_Ack && !reset) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("write", {DDR3_Address, DDR3_Write_Data}, e);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic quiet;
    Layer_Start = 0; Layer_End = 0; Result_Valid = 0; DDR3_Write_Ack = 0;
  endtask

  task automatic start_layer(input logic [31:0] base);
    quiet(); Layer_Start = 1; Base_Addr = base; tick(); Layer_Start = 0;
  endtask

  task automatic push(input logic [31:0] d, input logic ack);
    Result_Valid = 1; Result_Data = d; DDR3_Write_Ack = ack; tick(); Result_Valid = 0;
  endtask

  task automatic end_layer;
    quiet(); Layer_End = 1; tick(); Layer_End = 0;
  endtask

  // mode 0: ack every cycle, 1: every second cycle, 2: random
  task automatic drain(input int mode, input int budget);
    int f0 = flush_cnt;
    bit seen = 0;
    quiet();
    for (int i = 0; i < budget && !seen; i++) begin
      DDR3_Write_Ack = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(i % 2) : logic'($urandom % 2);
      tick();
      if (flush_cnt > f0) seen = 1;
    end
    if (!seen) chk("drain_timeout", 64'd0, 64'd1);
    quiet(); tick();
  endtask

  initial begin
    int f0;
    repeat (3) tick();
    chk("reset_outputs", {DDR3_WE, Almost_Full, Flush_Done, Drop_Err, Words_Written}, 64'd0);
    reset = 0;
    tick();

    // Basic layer: three words, ack every cycle
    f0 = flush_cnt;
    start_layer(32'h1000);
    push(32'hAAAA_0001, 1); push(32'hBBBB_0002, 1); push(32'hCCCC_0003, 1);
    end_layer();
    drain(0, 50);
    chk("basic_words", Words_Written, 64'd3);
    chk("basic_flush_pulses", flush_cnt - f0, 64'd1);

    // Backpressure, full-with-pop acceptance, then a dropped push
    start_layer(32'h2000);
    for (int i = 0; i < 16; i++) begin
      push(32'h5000_0000 + i, 0);
      if (i == 10) chk("af_after_11", Almost_Full, 64'd0);
      if (i == 11) chk("af_after_12", Almost_Full, 64'd1);
    end
    push(32'h5000_0010, 1);
    chk("full_pop_no_drop", Drop_Err, 64'd0);
    push(32'h5000_0011, 0);
    chk("full_drop", Drop_Err, 64'd1);
    end_layer();
    drain(0, 60);

    // Address wrap at the top of the address space
    start_layer(32'hFFFF_FFFC);
    push(32'h0000_00A1, 0); push(32'h0000_00A2, 0);
    end_layer();
    drain(0, 20);

    // Protocol: valid result in IDLE after a fresh reset
    reset = 1; tick(); reset = 0; tick();
    push(32'hDEAD_BEEF, 0);
    chk("idle_valid_drop", Drop_Err, 64'd1);
    chk("idle_valid_no_we", DDR3_WE, 64'd0);

    // Five queued words flushed with ack every second cycle
    f0 = flush_cnt;
    start_layer(32'h3000);
    for (int i = 0; i < 5; i++) push(32'h6000_0000 + i, 0);
    end_layer();
    drain(1, 40);
    chk("slow_flush_words", Words_Written, 64'd5);
    chk("slow_flush_pulses", flush_cnt - f0, 64'd1);

    // Reset in the middle of a flush with four words queued
    start_layer(32'h4000);
    for (int i = 0; i < 4; i++) push(32'h7000_0000 + i, 0);
    end_layer();
    tick();
    reset = 1;
    #1;
    chk("mid_flush_reset", {DDR3_WE, Almost_Full, Flush_Done, Drop_Err, DDR3_Address}, 64'd0);
    chk("mid_flush_reset_data", {Words_Written, DDR3_Write_Data}, 64'd0);
    tick(); reset = 0;
    DDR3_Write_Ack = 1;
    repeat (5) tick();
    quiet();

    // Randomized layers with random valid/ack activity
    for (int l = 0; l < 6; l++) begin
      start_layer($urandom);
      for (int c = 0; c < 40; c++) begin
        Result_Valid   = logic'($urandom % 3 != 0);
        Result_Data    = $urandom;
        DDR3_Write_Ack = (l % 2 == 0) ? logic'($urandom % 4 == 0) : logic'($urandom % 2);
        Layer_Start    = logic'($urandom % 8 == 0);
        tick();
      end
      end_layer();
      drain(2, 200);
    end

    chk("sb_empty_at_end", sb.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
